// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with programmable modulus, load, wrap/saturate, tc pulse and sticky ovf.
// Optional prescaler (div_val port) is enabled by defining COUNTER_PRESCALE_EN.
module updown_counter_param #(
    parameter int WIDTH = 4,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] max_val,
    input  logic             sat_mode,
    input  logic             clr_ovf,
`ifdef COUNTER_PRESCALE_EN
    input  logic [DIV_W-1:0] div_val,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    if (WIDTH < 2) begin : g_bad_width
        $error("updown_counter_param: WIDTH must be >= 2");
    end
    if (DIV_W < 1) begin : g_bad_div_w
        $error("updown_counter_param: DIV_W must be >= 1");
    end

    logic             w_tick;
    logic             w_step;
    logic             w_term;
    logic [WIDTH-1:0] w_next;

`ifdef COUNTER_PRESCALE_EN
    logic [DIV_W-1:0] r_presc;

    assign w_tick = (r_presc == div_val);

    // Prescaler freezes with en low and restarts its period on load.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            r_presc <= '0;
        end else if (en) begin
            r_presc <= w_tick ? '0 : r_presc + 1'b1;
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    assign w_step = en & w_tick;

    // Up terminal uses >= so a loaded value above max_val still terminates.
    always_comb begin
        w_term = 1'b0;
        w_next = count;
        if (up_dn) begin
            w_term = (count >= max_val);
            if (!w_term) begin
                w_next = count + 1'b1;
            end else if (!sat_mode) begin
                w_next = '0;
            end
        end else begin
            w_term = (count == '0);
            if (!w_term) begin
                w_next = count - 1'b1;
            end else if (!sat_mode) begin
                w_next = max_val;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else if (load) begin
            count <= load_val;
            tc    <= 1'b0;
            ovf   <= ovf & ~clr_ovf;
        end else if (w_step) begin
            count <= w_next;
            tc    <= w_term;
            ovf   <= w_term | (ovf & ~clr_ovf);
        end else begin
            tc    <= 1'b0;
            ovf   <= ovf & ~clr_ovf;
        end
    end

endmodule

// File: tb/tb_updown_counter_param.sv
// Directed table-driven bench for updown_counter_param (WIDTH=4); prescaler checks run when COUNTER_PRESCALE_EN is defined.
module tb_updown_counter_param;

    typedef struct {
        bit       rst;
        bit       en;
        bit       ud;
        bit       ld;
        bit [3:0] lv;
        bit [3:0] mv;
        bit       sat;
        bit       clr;
        bit [3:0] e_cnt;
        bit       e_tc;
        bit       e_ovf;
    } vec_t;

    logic       clk;
    logic       reset;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [3:0] load_val;
    logic [3:0] max_val;
    logic       sat_mode;
    logic       clr_ovf;
    logic [3:0] count;
    logic       tc;
    logic       ovf;
`ifdef COUNTER_PRESCALE_EN
    logic [7:0] div_val;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    vec_t vecs[$];

    updown_counter_param #(.WIDTH(4), .DIV_W(8)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up_dn    (up_dn),
        .load     (load),
        .load_val (load_val),
        .max_val  (max_val),
        .sat_mode (sat_mode),
        .clr_ovf  (clr_ovf),
`ifdef COUNTER_PRESCALE_EN
        .div_val  (div_val),
`endif
        .count    (count),
        .tc       (tc),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(input bit rst, input bit e, input bit ud, input bit ld,
                                input bit [3:0] lv, input bit [3:0] mv, input bit sat,
                                input bit clr, input bit [3:0] ec, input bit etc, input bit eovf);
        vec_t v;
        v.rst = rst; v.en = e; v.ud = ud; v.ld = ld; v.lv = lv; v.mv = mv;
        v.sat = sat; v.clr = clr; v.e_cnt = ec; v.e_tc = etc; v.e_ovf = eovf;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        reset = v.rst; en = v.en; up_dn = v.ud; load = v.ld; load_val = v.lv;
        max_val = v.mv; sat_mode = v.sat; clr_ovf = v.clr;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input bit [3:0] ec, input bit etc, input bit eovf);
        chk({tag, ".count"}, int'(count), int'(ec));
        chk({tag, ".tc"},    int'(tc),    int'(etc));
        chk({tag, ".ovf"},   int'(ovf),   int'(eovf));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        max_val = 4'd9; sat_mode = 1'b0; clr_ovf = 1'b0;
`ifdef COUNTER_PRESCALE_EN
        div_val = 8'd0;
`endif

        //              rst en ud ld lv  mv sat clr  cnt tc ovf
        vecs.push_back(mk(1, 0, 1, 0, 0, 9, 0, 0,   0, 0, 0));
        for (int i = 1; i <= 9; i++)
            vecs.push_back(mk(0, 1, 1, 0, 0, 9, 0, 0, 4'(i), 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 9, 0, 0,   0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 9, 0, 0,   1, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 9, 0, 0,   2, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 9, 0, 1,   2, 0, 0));
        // saturate up
        vecs.push_back(mk(1, 0, 1, 0, 0, 9, 1, 0,   0, 0, 0));
        for (int i = 1; i <= 9; i++)
            vecs.push_back(mk(0, 1, 1, 0, 0, 9, 1, 0, 4'(i), 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 9, 1, 0,   9, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 9, 1, 1,   9, 1, 1));
        vecs.push_back(mk(0, 0, 1, 0, 0, 9, 1, 1,   9, 0, 0));
        // load with en, then down wrap
        vecs.push_back(mk(0, 1, 0, 1, 3, 9, 0, 0,   3, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 9, 0, 0,   2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 9, 0, 0,   1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 9, 0, 0,   0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 9, 0, 0,   9, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 9, 0, 0,   8, 0, 1));
        // load above max_val
        vecs.push_back(mk(0, 0, 1, 1, 14, 9, 0, 0, 14, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 9, 0, 0,   0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 1, 14, 9, 1, 0, 14, 0, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 9, 1, 0,  14, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 9, 1, 0,  13, 0, 1));
        // reset beats load and en
        vecs.push_back(mk(1, 1, 1, 1, 7, 9, 0, 0,   0, 0, 0));
        // max_val = 0
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0,   0, 1, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 1, 0,   0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 1, 5, 0, 0, 0,   5, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0,   4, 0, 1));
        // direction changes with no dead cycle, then freeze
        vecs.push_back(mk(1, 0, 1, 0, 0, 9, 0, 0,   0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 9, 0, 0,   1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 9, 0, 0,   2, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 9, 0, 0,   1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 9, 0, 0,   2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 9, 0, 0,   2, 0, 0));
        // down wrap to a reduced max_val
        vecs.push_back(mk(0, 0, 0, 1, 0, 9, 0, 0,   0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4, 0, 0,   4, 1, 1));

        foreach (vecs[i]) begin
            drive(vecs[i]);
            check_all($sformatf("vec%0d", i), vecs[i].e_cnt, vecs[i].e_tc, vecs[i].e_ovf);
        end

        // Saturated at the limit: tc stays high for every enabled cycle, drops when en falls.
        drive(mk(0, 0, 1, 1, 6, 6, 1, 0, 6, 0, 1));
        for (int i = 0; i < 4; i++) begin
            drive(mk(0, 1, 1, 0, 0, 6, 1, 0, 6, 1, 1));
            check_all($sformatf("sat_hold%0d", i), 4'd6, 1'b1, 1'b1);
        end
        drive(mk(0, 0, 1, 0, 0, 6, 1, 0, 6, 0, 1));
        check_all("sat_release", 4'd6, 1'b0, 1'b1);

        // Lowering max_val below the count mid-run: next up step is terminal.
        drive(mk(1, 0, 1, 0, 0, 9, 0, 0, 0, 0, 0));
        for (int i = 1; i <= 5; i++) drive(mk(0, 1, 1, 0, 0, 9, 0, 0, 4'(i), 0, 0));
        chk("pre_shrink.count", int'(count), 5);
        drive(mk(0, 1, 1, 0, 0, 3, 0, 0, 0, 1, 1));
        check_all("shrink_wrap", 4'd0, 1'b1, 1'b1);
        drive(mk(0, 1, 1, 0, 0, 3, 0, 0, 1, 0, 1));
        check_all("shrink_next", 4'd1, 1'b0, 1'b1);

`ifdef COUNTER_PRESCALE_EN
        drive(mk(1, 0, 1, 0, 0, 9, 0, 0, 0, 0, 0));
        div_val = 8'd2;
        begin
            int exp_seq[6] = '{0, 0, 1, 1, 1, 2};
            for (int i = 0; i < 6; i++) begin
                drive(mk(0, 1, 1, 0, 0, 9, 0, 0, 0, 0, 0));
                chk($sformatf("presc%0d.count", i), int'(count), exp_seq[i]);
            end
        end
        drive(mk(0, 1, 1, 0, 0, 9, 0, 0, 0, 0, 0));
        chk("presc_mid.count", int'(count), 2);
        drive(mk(0, 1, 1, 1, 5, 9, 0, 0, 0, 0, 0));
        chk("presc_load.count", int'(count), 5);
        begin
            int exp_ld[3] = '{5, 5, 6};
            for (int i = 0; i < 3; i++) begin
                drive(mk(0, 1, 1, 0, 0, 9, 0, 0, 0, 0, 0));
                chk($sformatf("presc_ld%0d.count", i), int'(count), exp_ld[i]);
            end
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
